combo_ctrl: RTL

- Upstream command sequencer for the combo unit (2:1 mux / 4:2 encoder / 2:4 decoder selected by choice).
- Accepts op requests over a valid/ready command channel and buffers them in a small FIFO.
- Drives the combo inputs from registers and waits a programmable settle time. It then samples the combo outputs and returns one response per command over a valid/ready response channel.

---
 rtl/combo_ctrl_pkg.sv | 24 ++
 rtl/combo_cmd_fifo.sv | 58 +++++
 rtl/combo_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/combo_ctrl_pkg.sv
// rtl/combo_ctrl_pkg.sv - op codes, FSM states and shared helpers for combo_ctrl
package combo_ctrl_pkg;

    localparam logic [1:0] OP_MUX = 2'b00;
    localparam logic [1:0] OP_ENC = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] data;
    } cmd_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/combo_cmd_fifo.sv
// rtl/combo_cmd_fifo.sv - synchronous command FIFO holding {op,data} entries
module combo_cmd_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [5:0] din,
    input  logic       pop,
    output logic [5:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [5:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/combo_ctrl.sv
// rtl/combo_ctrl.sv - command sequencer driving the combo unit and returning sampled results
module combo_ctrl
    import combo_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_op,
    output logic [3:0] rsp_data,
    output logic       rsp_err,
    output logic [1:0] choice,
    output logic       sel,
    output logic       I0,
    output logic       I1,
    output logic [3:0] enc_in,
    output logic [1:0] dec_in,
    input  logic       mux_out,
    input  logic [1:0] enc_out,
    input  logic [3:0] dec_out
);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic       fifo_full, fifo_empty, fifo_pop;
    logic [5:0] fifo_dout;
    cmd_t       head;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [1:0]    rsp_op_q, rsp_op_d;
    logic [3:0]    rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic [1:0]    choice_q, choice_d;
    logic          sel_q, sel_d, i0_q, i0_d, i1_q, i1_d;
    logic [3:0]    enc_in_q, enc_in_d;
    logic [1:0]    dec_in_q, dec_in_d;

    combo_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .din   ({cmd_op, cmd_data}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head      = cmd_t'(fifo_dout);
    assign cmd_ready = !fifo_full;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_op_d    = rsp_op_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        choice_d    = choice_q;
        sel_d       = sel_q;
        i0_d        = i0_q;
        i1_d        = i1_q;
        enc_in_d    = enc_in_q;
        dec_in_d    = dec_in_q;
        fifo_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    rsp_op_d = head.op;
                    if (head.op == OP_RSV) begin
                        // Reserved op never touches the combo drive registers.
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = 4'd0;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        choice_d = head.op;
                        case (head.op)
                            OP_MUX:  {sel_d, i0_d, i1_d} = head.data[2:0];
                            OP_ENC:  enc_in_d = head.data;
                            default: dec_in_d = head.data[1:0];
                        endcase
                        cnt_d   = CW'(SETTLE_CYCLES - 1);
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    case (choice_q)
                        OP_MUX: begin
                            rsp_data_d = {3'b000, mux_out};
                            rsp_err_d  = 1'b0;
                        end
                        OP_ENC: begin
                            rsp_data_d = {2'b00, enc_out};
                            rsp_err_d  = !is_onehot4(enc_in_q);
                        end
                        OP_DEC: begin
                            rsp_data_d = dec_out;
                            rsp_err_d  = 1'b0;
                        end
                        default: begin
                            rsp_data_d = 4'd0;
                            rsp_err_d  = 1'b1;
                        end
                    endcase
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_op_q    <= 2'd0;
            rsp_data_q  <= 4'd0;
            rsp_err_q   <= 1'b0;
            choice_q    <= 2'd0;
            sel_q       <= 1'b0;
            i0_q        <= 1'b0;
            i1_q        <= 1'b0;
            enc_in_q    <= 4'd0;
            dec_in_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_op_q    <= rsp_op_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            choice_q    <= choice_d;
            sel_q       <= sel_d;
            i0_q        <= i0_d;
            i1_q        <= i1_d;
            enc_in_q    <= enc_in_d;
            dec_in_q    <= dec_in_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign choice    = choice_q;
    assign sel       = sel_q;
    assign I0        = i0_q;
    assign I1        = i1_q;
    assign enc_in    = enc_in_q;
    assign dec_in    = dec_in_q;

endmodule
